// File: rtl/mult_pipe_cfg_pkg.sv
// mult_pipe_cfg shared definitions.
// Mode encodings and digit-count helpers.
package mult_pipe_cfg_pkg;

  localparam logic [1:0] MODE_EXACT  = 2'd0;
  localparam logic [1:0] MODE_CLR2   = 2'd1;
  localparam logic [1:0] MODE_CLR4   = 2'd2;
  localparam logic [1:0] MODE_CLR4_C = 2'd3;

  function automatic int q_of(input int w);
    return w / 4;
  endfunction

  function automatic int p_of(input int w);
    return q_of(w) * q_of(w);
  endfunction

endpackage

// File: rtl/mult_pipe_cfg_if.sv
// mult_pipe_cfg operand/result/config bus.
// master drives operands and config, slave is the multiplier.
interface mult_pipe_cfg_if
  import mult_pipe_cfg_pkg::*;
#(
  parameter int W = 8
);

  localparam int P = p_of(W);

  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           in_valid;
  logic           in_ready;
  logic           cfg_we;
  logic [2*P-1:0] cfg_data;
  logic [2*W-1:0] R;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output A, B, in_valid, cfg_we, cfg_data, out_ready,
    input  in_ready, R, out_valid
  );

  modport slave (
    input  A, B, in_valid, cfg_we, cfg_data, out_ready,
    output in_ready, R, out_valid
  );

endinterface

// File: rtl/mult_pipe_cfg_lm4.sv
// lm4_cfg: 4x4 digit multiplier with
// configurable low-bit approximation.
module lm4_cfg
  import mult_pipe_cfg_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] mode,
  output logic [7:0] p
);

  logic [7:0] ex;

  assign ex = {4'b0000, a} * {4'b0000, b};

  // apply the selected low-bit modification
  always_comb begin
    p = ex;
    unique case (mode)
      MODE_EXACT:  p = ex;
      MODE_CLR2:   p = {ex[7:2], 2'b00};
      MODE_CLR4:   p = {ex[7:4], 4'b0000};
      MODE_CLR4_C: p = {ex[7:4], 4'b1000};
    endcase
  end

endmodule

// File: rtl/mult_pipe_cfg.sv
// mult_pipe_cfg: 3-stage configurable
// approximate multiplier with stall.
module mult_pipe_cfg
  import mult_pipe_cfg_pkg::*;
#(
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst,
  mult_pipe_cfg_if.slave bus
);

  localparam int Q = q_of(W);
  localparam int P = p_of(W);

  logic [2*P-1:0] mode_reg;
  logic           adv;

  logic           v1;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic [2*P-1:0] m1;

  logic [7:0]     sp [P];
  logic [7:0]     pp [P];
  logic           v2;

  logic [2*W-1:0] sum;
  logic [2*W-1:0] r_q;
  logic           ov_q;

  assign adv          = !ov_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.R        = r_q;
  assign bus.out_valid = ov_q;

  // mode register; writes land even while stalled
  always_ff @(posedge clk) begin
    if (rst)
      mode_reg <= '0;
    else if (bus.cfg_we)
      mode_reg <= bus.cfg_data;
  end

  // S1: capture operands with the current mode
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      a1 <= bus.A;
      b1 <= bus.B;
      m1 <= mode_reg;
    end
  end

  for (genvar gi = 0; gi < Q; gi++) begin : g_i
    for (genvar gj = 0; gj < Q; gj++) begin : g_j
      lm4_cfg u_lm4 (
        .a    (a1[4*gi +: 4]),
        .b    (b1[4*gj +: 4]),
        .mode (m1[2*(gi*Q+gj) +: 2]),
        .p    (sp[gi*Q+gj])
      );
    end
  end

  // S2: register all sub-products
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (adv) begin
      v2 <= v1;
      pp <= sp;
    end
  end

  // weighted sum of the sub-products
  always_comb begin
    sum = '0;
    for (int i = 0; i < Q; i++)
      for (int j = 0; j < Q; j++)
        sum = sum + ((2*W)'(pp[i*Q+j]) << (4*(i+j)));
  end

  // S3: result register, held under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      r_q  <= '0;
    end else if (adv) begin
      ov_q <= v2;
      if (v2)
        r_q <= sum;
    end
  end

endmodule
